// File: rtl/gauss_column_feeder.sv
// Turns a raster pixel stream into three-column bursts (rows r-2, r-1, r) for a 3x3 Gaussian filter.
// Two line buffers hold the previous rows and a three-deep window holds the most recent columns.
module gauss_column_feeder #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_valid,
    input  logic [7:0] pix_in,
    output logic       pix_ready,
    input  logic       done,
    output logic       enable,
    output logic [7:0] In1,
    output logic [7:0] In2,
    output logic [7:0] In3,
    output logic       frame_done
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [2:0] {
        ACCEPT,
        BURST0,
        BURST1,
        BURST2,
        WAIT_DONE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_ready;
    logic          r_enable;
    logic          r_frameDone;
    logic          r_lastWin;
    logic [7:0]    r_in1;
    logic [7:0]    r_in2;
    logic [7:0]    r_in3;

    logic [7:0]    r_lb0 [IMG_WIDTH];
    logic [7:0]    r_lb1 [IMG_WIDTH];
    logic [23:0]   r_w0;
    logic [23:0]   r_w1;
    logic [23:0]   r_w2;

    logic          w_accept;
    logic          w_colEnd;
    logic          w_rowEnd;
    logic          w_window;
    logic [23:0]   w_column;

    assign w_accept = pix_valid && r_ready;
    assign w_colEnd = (r_col == CW'(IMG_WIDTH - 1));
    assign w_rowEnd = (r_row == RW'(IMG_HEIGHT - 1));
    assign w_window = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_column = {r_lb0[r_col], r_lb1[r_col], pix_in};

    // Pixel storage carries no reset: it is always rewritten before any window can expose it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= pix_in;
            r_w0         <= r_w1;
            r_w1         <= r_w2;
            r_w2         <= w_column;
        end
    end

    // Outputs are loaded one state ahead, so BURST0 shows r_w1 (which becomes W0 on the same edge).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ACCEPT;
            r_col       <= '0;
            r_row       <= '0;
            r_ready     <= 1'b1;
            r_enable    <= 1'b0;
            r_in1       <= 8'd0;
            r_in2       <= 8'd0;
            r_in3       <= 8'd0;
            r_frameDone <= 1'b0;
            r_lastWin   <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            case (r_state)
                ACCEPT: begin
                    if (w_accept) begin
                        if (w_colEnd) begin
                            r_col <= '0;
                            r_row <= w_rowEnd ? '0 : r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                        if (w_window) begin
                            r_state                <= BURST0;
                            r_ready                <= 1'b0;
                            r_enable               <= 1'b1;
                            {r_in1, r_in2, r_in3}  <= r_w1;
                            r_lastWin              <= w_colEnd && w_rowEnd;
                        end
                    end
                end
                BURST0: begin
                    r_state               <= BURST1;
                    r_enable              <= 1'b0;
                    {r_in1, r_in2, r_in3} <= r_w1;
                end
                BURST1: begin
                    r_state               <= BURST2;
                    {r_in1, r_in2, r_in3} <= r_w2;
                end
                BURST2: begin
                    r_state               <= WAIT_DONE;
                    {r_in1, r_in2, r_in3} <= 24'd0;
                end
                WAIT_DONE: begin
                    if (done) begin
                        r_state     <= ACCEPT;
                        r_ready     <= 1'b1;
                        r_frameDone <= r_lastWin;
                    end
                end
                default: begin
                    r_state               <= ACCEPT;
                    r_ready               <= 1'b1;
                    r_enable              <= 1'b0;
                    {r_in1, r_in2, r_in3} <= 24'd0;
                end
            endcase
        end
    end

    assign pix_ready  = r_ready;
    assign enable     = r_enable;
    assign In1        = r_in1;
    assign In2        = r_in2;
    assign In3        = r_in3;
    assign frame_done = r_frameDone;

endmodule
